// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: control/display bundle for seg7_scan_ctrl.
//   iEN     scan enable (0 = display dark)
//   iLOAD   1-cycle strobe, captures iVALUE into the shadow register
//   iVALUE  value to display, nibble k -> digit k
//   oDIG    nibble for the shared hex-to-segment decoder
//   oAN     digit enables, active-low
//   oACK    1-cycle pulse when the shadow value is committed
//   oFRAME  1-cycle pulse marking the frame wrap
// master = value/enable source, slave = scan controller.
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
) ();
    logic                iEN;
    logic                iLOAD;
    logic [4*NDIG-1:0]   iVALUE;
    logic [3:0]          oDIG;
    logic [NDIG-1:0]     oAN;
    logic                oACK;
    logic                oFRAME;

    modport master (
        output iEN, iLOAD, iVALUE,
        input  oDIG, oAN, oACK, oFRAME
    );

    modport slave (
        input  iEN, iLOAD, iVALUE,
        output oDIG, oAN, oACK, oFRAME
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for NDIG common-anode
// 7-segment digits sharing one hex decoder. Each digit gets BLANK_CYC dark
// cycles (decoder setup, anti-ghosting) followed by DWELL lit cycles.
// The display value is double-buffered: iLOAD captures into a shadow register,
// which is committed to the display register only at the frame wrap (or at
// once while scanning is disabled), so a frame never tears.
// Ports:
//   iCLK    system clock, rising edge
//   iRST_N  asynchronous active-low reset
//   bus     seg7_scan_ctrl_if.slave (iEN, iLOAD, iVALUE, oDIG, oAN, oACK, oFRAME)
// All outputs are registered.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking (digit k>0
// stays dark during its slot when nibbles k..NDIG-1 are all zero).
module seg7_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic           iCLK,
    input  logic           iRST_N,
    seg7_scan_ctrl_if.slave bus
);

    localparam int CMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = $clog2(NDIG);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*NDIG-1:0]   shadow_q, shadow_d;
    logic [4*NDIG-1:0]   disp_q, disp_d;
    logic                pend_q, pend_d;
    logic [3:0]          dig_q, dig_d;
    logic [NDIG-1:0]     an_q, an_d;
    logic                ack_q, ack_d;
    logic                frame_q, frame_d;
    logic                wrap;
    logic                commit;
    logic                dark;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        wrap     = 1'b0;

        if (!bus.iEN) begin
            state_d = BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (state_q == BLANK) begin
            if (cnt_q == CW'(BLANK_CYC - 1)) begin
                state_d = SHOW;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == CW'(DWELL - 1)) begin
                state_d = BLANK;
                cnt_d   = '0;
                if (idx_q == IW'(NDIG - 1)) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        commit = pend_q && (wrap || !bus.iEN);
        if (commit) begin
            disp_d = shadow_q;
        end
        // A load on the commit edge re-arms pending with the new value.
        if (bus.iLOAD) begin
            shadow_d = bus.iVALUE;
            pend_d   = 1'b1;
        end else if (commit) begin
            pend_d = 1'b0;
        end

        // Outputs are derived from the next state so oAN/oDIG track it exactly.
        dig_d = disp_d[4*32'(idx_d) +: 4];
        an_d  = '1;
        if (state_d == SHOW && !dark) begin
            an_d[idx_d] = 1'b0;
        end
        ack_d   = commit;
        frame_d = wrap;
    end

`ifdef SEG7_LZB_EN
    always_comb begin
        dark = 1'b0;
        if (idx_d != '0) begin
            dark = 1'b1;
            for (int unsigned k = 0; k < NDIG; k++) begin
                if (k >= 32'(idx_d) && disp_d[4*k +: 4] != 4'h0) begin
                    dark = 1'b0;
                end
            end
        end
    end
`else
    assign dark = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= BLANK;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            dig_q    <= '0;
            an_q     <= '1;
            ack_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            dig_q    <= dig_d;
            an_q     <= an_d;
            ack_q    <= ack_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.oDIG   = dig_q;
    assign bus.oAN    = an_q;
    assign bus.oACK   = ack_q;
    assign bus.oFRAME = frame_q;

endmodule
